// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared constants and types for the RV32M multiply/divide sequencer:
//   instruction-field encodings, the sequencer state type and a small
//   funct3 classification helper.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   Shared iterative engine: shift-add multiplier and restoring divider on
//   unsigned magnitudes, plus the iteration counter.
//   Ports:
//     clk, reset          clock, async active-high reset
//     load                latch operands and mode, arm counter for XLEN steps
//     step                perform one iteration
//     finish              clear the counter (completion or abort)
//     div_mode            1 = divide, 0 = multiply (sampled on load)
//     load_a, load_b      magnitudes: multiplier/dividend, multiplicand/divisor
//     last                counter has reached zero (final iteration)
//     acc_next            accumulator value after the current step
//                         multiply: {product_hi, product_lo}
//                         divide:   {remainder, quotient}
module muldiv_datapath #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              finish,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   load_a,
  input  logic [XLEN-1:0]   load_b,
  output logic              last,
  output logic [2*XLEN-1:0] acc_next
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opb_r;
  logic              div_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] step_val_s;

  // One iteration of either engine; the carry/borrow bit is kept at XLEN+1.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (div_r) begin
      // Restore when the trial subtraction borrows.
      if (div_diff_s[XLEN]) begin
        step_val_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
        step_val_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      step_val_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  assign acc_next = step_val_s;
  assign last     = (cnt_r == {CNT_W{1'b0}});

  // Operand, accumulator and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= {(2*XLEN){1'b0}};
      opb_r <= {XLEN{1'b0}};
      div_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      acc_r <= {{XLEN{1'b0}}, load_a};
      opb_r <= load_b;
      div_r <= div_mode;
      cnt_r <= CNT_LOAD;
    end else begin
      if (step) begin
        acc_r <= step_val_s;
      end else begin
        acc_r <= acc_r;
      end
      if (finish) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (step) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
//   Execute-stage sequencer for RV32M ops. Detects an M op in ID/EX, stalls
//   the front of the pipeline while muldiv_datapath iterates, and delivers a
//   registered result with a one-cycle out_valid pulse in the DONE state.
//   Sign handling and the divide-by-zero / overflow shortcuts live here.
//   Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
//   product registered at accept; divides stay iterative.
//   Ports:
//     clk, reset            clock, async active-high reset
//     in_valid              ID/EX holds a valid instruction
//     in_opcode, in_funct7  decode fields identifying an M op
//     in_funct3             M-op select
//     in_rs1, in_rs2        forwarded operands
//     in_flush              abort any op in flight
//     out_stall             freeze PC, IF/ID, ID/EX
//     out_valid             out_result valid (one-cycle pulse)
//     out_result            result, held until the next completion
//     out_busy              sequencer not idle
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [6:0]      in_opcode,
  input  logic [6:0]      in_funct7,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            in_flush,
  output logic            out_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_busy
);

  localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] XONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] XZERO = {XLEN{1'b0}};

  md_state_t         state_r;
  logic [XLEN-1:0]   result_r;
  logic              valid_r;
  logic [2:0]        f3_r;
  logic              neg_main_r;
  logic              neg_rem_r;

  logic              start_s, div_op_s, run_s, step_s, finish_s, load_s, last_s;
  logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic              div_zero_s, div_ovf_s, quick_s, fast_mul_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s, quick_res_s, iter_res_s, fast_res_s;
  logic [2*XLEN-1:0] acc_next_s;

  // Map the unsigned engine output back to the architectural result.
  // neg_main: product or quotient negative; neg_rem: remainder negative.
  function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f3,
                                                 input logic neg_main,
                                                 input logic neg_rem,
                                                 input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    if (is_div(f3)) begin
      if (f3[1]) begin
        res = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end else begin
        res = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      end
    end else begin
      prod = neg_main ? -acc : acc;
      res  = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    return res;
  endfunction

  // Decode, operand magnitudes and accept-time shortcuts.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (in_funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F3_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s    = a_signed_s & in_rs1[XLEN-1];
    b_neg_s    = b_signed_s & in_rs2[XLEN-1];
    mag_a_s    = a_neg_s ? -in_rs1 : in_rs1;
    mag_b_s    = b_neg_s ? -in_rs2 : in_rs2;
    div_op_s   = is_div(in_funct3);
    div_zero_s = div_op_s & (in_rs2 == XZERO);
    div_ovf_s  = div_op_s & ~in_funct3[0] & (in_rs1 == XMIN) & (in_rs2 == XONES);
    if (div_zero_s) begin
      special_res_s = in_funct3[1] ? in_rs1 : XONES;
    end else if (div_ovf_s) begin
      special_res_s = in_funct3[1] ? XZERO : XMIN;
    end else begin
      special_res_s = XZERO;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_prod_s = {{XLEN{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s};
  assign fast_mul_s  = ~div_op_s;
  assign fast_res_s  = fix_result(in_funct3, a_neg_s ^ b_neg_s, 1'b0, fast_prod_s);
`else
  assign fast_mul_s  = 1'b0;
  assign fast_res_s  = XZERO;
`endif

  assign quick_s     = div_zero_s | div_ovf_s | fast_mul_s;
  assign quick_res_s = fast_mul_s ? fast_res_s : special_res_s;

  // reset is folded in so a held instruction cannot raise out_stall while reset is asserted.
  assign start_s  = in_valid & (in_opcode == OPCODE_OP) & (in_funct7 == FUNCT7_MULDIV) &
                    (state_r == MD_IDLE) & ~in_flush & ~reset;
  assign run_s    = (state_r == MD_MUL) | (state_r == MD_DIV);
  assign load_s   = start_s & ~quick_s;
  assign step_s   = run_s & ~in_flush;
  assign finish_s = run_s & (in_flush | last_s);

  assign iter_res_s = fix_result(f3_r, neg_main_r, neg_rem_r, acc_next_s);

  muldiv_datapath #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .finish   (finish_s),
    .div_mode (div_op_s),
    .load_a   (mag_a_s),
    .load_b   (mag_b_s),
    .last     (last_s),
    .acc_next (acc_next_s)
  );

  // Sequencer FSM with registered result and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= MD_IDLE;
      result_r   <= XZERO;
      valid_r    <= 1'b0;
      f3_r       <= 3'b000;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (start_s) begin
            f3_r       <= in_funct3;
            neg_main_r <= a_neg_s ^ b_neg_s;
            neg_rem_r  <= a_neg_s;
            if (quick_s) begin
              state_r  <= MD_DONE;
              result_r <= quick_res_s;
              valid_r  <= 1'b1;
            end else if (div_op_s) begin
              state_r <= MD_DIV;
            end else begin
              state_r <= MD_MUL;
            end
          end else begin
            state_r <= MD_IDLE;
          end
        end
        MD_MUL, MD_DIV: begin
          if (in_flush) begin
            state_r <= MD_IDLE;
          end else if (last_s) begin
            state_r  <= MD_DONE;
            result_r <= iter_res_s;
            valid_r  <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        MD_DONE: begin
          state_r <= MD_IDLE;
        end
        default: begin
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

  assign out_stall  = start_s | run_s;
  assign out_valid  = valid_r & ~in_flush;
  assign out_result = result_r;
  assign out_busy   = (state_r != MD_IDLE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed testbench for ex_muldiv_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 time unit after the falling edge. Cycle 0 is the
// accept cycle (the half period ending at the accepting rising edge).
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [6:0]  in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        in_flush;
  logic        out_stall;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_funct7  (in_funct7),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_flush   (in_flush),
    .out_stall  (out_stall),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_busy   (out_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    in_opcode = OPCODE_OP;
    in_funct7 = FUNCT7_MULDIV;
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
  endtask

  // Issue one op, hold in_valid through DONE, then drop it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    int          nvalid;
    int          vcyc;
    logic [31:0] res;
    nvalid = 0;
    vcyc   = -1;
    res    = 32'h0000_0000;
    @(negedge clk);
    drive_op(f3, a, b);
    #1;
    for (int c = 0; c <= lat + 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (c < lat) begin
        check({tag, " stall"}, 32'(out_stall), 32'd1);
      end else if (c == lat) begin
        check({tag, " stall in done"}, 32'(out_stall), 32'd0);
      end
      if (out_valid === 1'b1) begin
        nvalid++;
        vcyc = c;
        res  = out_result;
      end
      if (c == lat) begin
        in_valid = 1'b0;
      end
    end
    check({tag, " valid count"}, 32'(nvalid), 32'd1);
    check({tag, " valid cycle"}, 32'(vcyc), 32'(lat));
    check({tag, " result"}, res, exp);
    check({tag, " result held"}, out_result, exp);
    check({tag, " busy after"}, 32'(out_busy), 32'd0);
  endtask

  initial begin
    int nvalid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 7'b0000000;
    in_funct7 = 7'b0000000;
    in_funct3 = 3'b000;
    in_rs1    = 32'h0000_0000;
    in_rs2    = 32'h0000_0000;
    in_flush  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", 32'(out_stall), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset result", out_result, 32'h0000_0000);
    check("reset busy", 32'(out_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("MUL 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB);
    run_op("MULHU", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE);
    run_op("MULH", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0000_0000);
    run_op("MULHSU", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFF);
    run_op("MUL shift", F3_MUL, 32'h1234_5678, 32'h0000_0010, MUL_LAT, 32'h2345_6780);
    run_op("REM -7%2", F3_REM, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF);
    run_op("DIV -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFD);
    run_op("DIVU 100/7", F3_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd14);
    run_op("REMU 100%7", F3_REMU, 32'd100, 32'd7, DIV_LAT, 32'd2);
    run_op("DIVU max/1", F3_DIVU, 32'hFFFF_FFFF, 32'd1, DIV_LAT, 32'hFFFF_FFFF);
    run_op("DIVU 5/0", F3_DIVU, 32'd5, 32'd0, SPC_LAT, 32'hFFFF_FFFF);
    run_op("REMU 5%0", F3_REMU, 32'd5, 32'd0, SPC_LAT, 32'd5);
    run_op("DIV ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, SPC_LAT, 32'h8000_0000);
    run_op("REM ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, SPC_LAT, 32'h0000_0000);

    // Flush at cycle 10 of a divide.
    @(negedge clk);
    drive_op(F3_DIVU, 32'd100, 32'd7);
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
    end
    check("flush div busy c10", 32'(out_busy), 32'd1);
    in_flush = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    in_flush = 1'b0;
    check("flush div busy c11", 32'(out_busy), 32'd0);
    check("flush div stall c11", 32'(out_stall), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) nvalid++;
    end
    check("flush div no valid", 32'(nvalid), 32'd0);
    run_op("MUL after flush", F3_MUL, 32'd6, 32'd9, MUL_LAT, 32'd54);

    // Flush in the same cycle as start.
    @(negedge clk);
    drive_op(F3_MUL, 32'd3, 32'd3);
    in_flush = 1'b1;
    #1;
    check("flush at start stall", 32'(out_stall), 32'd0);
    @(negedge clk);
    #1;
    check("flush at start busy", 32'(out_busy), 32'd0);
    in_flush = 1'b0;
    in_valid = 1'b0;

    // Flush during DONE suppresses out_valid.
    @(negedge clk);
    drive_op(F3_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    in_flush = 1'b1;
    #1;
    check("flush in done busy", 32'(out_busy), 32'd1);
    check("flush in done valid", 32'(out_valid), 32'd0);
    in_flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("flush in done idle", 32'(out_busy), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drive_op(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid reset stall", 32'(out_stall), 32'd0);
    check("mid reset valid", 32'(out_valid), 32'd0);
    check("mid reset busy", 32'(out_busy), 32'd0);
    check("mid reset result", out_result, 32'h0000_0000);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op("MUL after reset", F3_MUL, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
